// File: rtl/rv_dp_pkg.sv
// Shared datapath package: XLEN, handshake bundle,
// and a clog2 helper that never returns less than 1.
package rv_dp_pkg;

  localparam int XLEN = 32;

  typedef struct packed {
    logic valid;
    logic ready;
  } hs_t;

  function automatic int clog2_min1(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/mux_skid_buf.sv
// Two-entry output/skid register pair with valid/ready.
// in_ready comes straight from the skid flag, never from out_ready.
module mux_skid_buf #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready
);

  logic [WIDTH-1:0] skid_data;
  logic             skid_valid;
  logic             accept;
  logic             load;

  assign in_ready = ~skid_valid;
  assign accept   = in_valid & in_ready;
  assign load     = ~out_valid | out_ready;

  // Output register: skid word first, else the new word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (load) begin
      if (skid_valid) begin
        out_valid <= 1'b1;
        out_data  <= skid_data;
      end else if (accept) begin
        out_valid <= 1'b1;
        out_data  <= in_data;
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

  // Skid entry: catches an accept while the output stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      skid_valid <= 1'b0;
      skid_data  <= '0;
    end else if (load) begin
      skid_valid <= 1'b0;
    end else if (accept) begin
      skid_valid <= 1'b1;
      skid_data  <= in_data;
    end
  end

endmodule

// File: rtl/mux_n_reg_stage.sv
// N:1 registered operand select with valid/ready,
// skid buffering and a sticky out-of-range flag.
module mux_n_reg_stage
  import rv_dp_pkg::*;
#(
  parameter  int WIDTH  = XLEN,
  parameter  int NUM_IN = 2,
  localparam int SEL_W  = clog2_min1(NUM_IN)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_IN*WIDTH-1:0] data_in,
  input  logic [SEL_W-1:0]        sel,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    sel_err,
  input  logic                    clear_err
);

  hs_t              in_hs;
  logic             accept;
  logic [WIDTH-1:0] sel_word;
  logic             sel_ok;

  assign in_hs  = '{valid: in_valid, ready: in_ready};
  assign accept = in_hs.valid & in_hs.ready;

  // Binary-indexed select; an unmatched index yields zero.
  always_comb begin
    sel_word = '0;
    sel_ok   = 1'b0;
    for (int k = 0; k < NUM_IN; k++) begin
      if (sel == SEL_W'(k)) begin
        sel_word = data_in[k*WIDTH +: WIDTH];
        sel_ok   = 1'b1;
      end
    end
  end

  // Sticky error: a bad accept beats a same-cycle clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_err <= 1'b0;
    end else if (accept && !sel_ok) begin
      sel_err <= 1'b1;
    end else if (clear_err) begin
      sel_err <= 1'b0;
    end
  end

  mux_skid_buf #(
    .WIDTH(WIDTH)
  ) u_skid (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_data  (sel_word),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .out_data (out_data),
    .out_valid(out_valid),
    .out_ready(out_ready)
  );

endmodule

// File: tb/tb_mux_n_reg_stage.sv
// Directed and randomised checks of mux_n_reg_stage
// across four parameter sets.
module tb_mux_n_reg_stage;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;

  // a: WIDTH=32 NUM_IN=4
  logic [127:0] a_data;
  logic [1:0]   a_sel;
  logic a_iv, a_ir, a_ov, a_or, a_err, a_clr;
  logic [31:0]  a_od;
  // b: WIDTH=8 NUM_IN=5
  logic [39:0]  b_data;
  logic [2:0]   b_sel;
  logic b_iv, b_ir, b_ov, b_or, b_err, b_clr;
  logic [7:0]   b_od;
  // c: WIDTH=32 NUM_IN=3
  logic [95:0]  c_data;
  logic [1:0]   c_sel;
  logic c_iv, c_ir, c_ov, c_or, c_err, c_clr;
  logic [31:0]  c_od;
  // d: WIDTH=64 NUM_IN=2
  logic [127:0] d_data;
  logic [0:0]   d_sel;
  logic d_iv, d_ir, d_ov, d_or, d_err, d_clr;
  logic [63:0]  d_od;

  mux_n_reg_stage #(.WIDTH(32), .NUM_IN(4)) u_a (
    .clk(clk), .rst_n(rst_n), .data_in(a_data), .sel(a_sel),
    .in_valid(a_iv), .in_ready(a_ir), .out_data(a_od),
    .out_valid(a_ov), .out_ready(a_or), .sel_err(a_err),
    .clear_err(a_clr));

  mux_n_reg_stage #(.WIDTH(8), .NUM_IN(5)) u_b (
    .clk(clk), .rst_n(rst_n), .data_in(b_data), .sel(b_sel),
    .in_valid(b_iv), .in_ready(b_ir), .out_data(b_od),
    .out_valid(b_ov), .out_ready(b_or), .sel_err(b_err),
    .clear_err(b_clr));

  mux_n_reg_stage #(.WIDTH(32), .NUM_IN(3)) u_c (
    .clk(clk), .rst_n(rst_n), .data_in(c_data), .sel(c_sel),
    .in_valid(c_iv), .in_ready(c_ir), .out_data(c_od),
    .out_valid(c_ov), .out_ready(c_or), .sel_err(c_err),
    .clear_err(c_clr));

  mux_n_reg_stage #(.WIDTH(64), .NUM_IN(2)) u_d (
    .clk(clk), .rst_n(rst_n), .data_in(d_data), .sel(d_sel),
    .in_valid(d_iv), .in_ready(d_ir), .out_data(d_od),
    .out_valid(d_ov), .out_ready(d_or), .sel_err(d_err),
    .clear_err(d_clr));

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] ref_b(input logic [39:0] d,
                                       input logic [2:0] s);
    logic [7:0] r;
    r = 8'h00;
    if (s < 3'd5) r = d[s*8 +: 8];
    return r;
  endfunction

  function automatic logic [63:0] ref_d(input logic [127:0] d,
                                        input logic [0:0] s);
    return s[0] ? d[127:64] : d[63:0];
  endfunction

  task automatic test_reset();
    a_data = '0; a_sel = '0; a_iv = 0; a_or = 0; a_clr = 0;
    b_data = '0; b_sel = '0; b_iv = 0; b_or = 0; b_clr = 0;
    c_data = '0; c_sel = '0; c_iv = 0; c_or = 0; c_clr = 0;
    d_data = '0; d_sel = '0; d_iv = 0; d_or = 0; d_clr = 0;
    rst_n = 1'b0;
    cyc();
    cyc();
    n_cmp++; if (a_ov !== 1'b0) begin n_fail++; $display("FAIL rst_ov got %b want 0", a_ov); end
    n_cmp++; if (a_od !== 32'h0) begin n_fail++; $display("FAIL rst_od got %h want 0", a_od); end
    n_cmp++; if (a_err !== 1'b0) begin n_fail++; $display("FAIL rst_err got %b want 0", a_err); end
    rst_n = 1'b1;
    cyc();
    n_cmp++; if (a_ir !== 1'b1) begin n_fail++; $display("FAIL rst_ir got %b want 1", a_ir); end
  endtask

  task automatic test_stream();
    logic [31:0] exp [4];
    exp = '{32'h11, 32'h22, 32'h33, 32'h44};
    a_data = {32'h44, 32'h33, 32'h22, 32'h11};
    a_or = 1'b1;
    for (int i = 0; i < 4; i++) begin
      a_iv = 1'b1;
      a_sel = 2'(i);
      cyc();
      n_cmp++; if (a_ov !== 1'b1) begin n_fail++; $display("FAIL stream_ov%0d got %b want 1", i, a_ov); end
      n_cmp++; if (a_od !== exp[i]) begin n_fail++; $display("FAIL stream_od%0d got %h want %h", i, a_od, exp[i]); end
      n_cmp++; if (a_ir !== 1'b1) begin n_fail++; $display("FAIL stream_ir%0d got %b want 1", i, a_ir); end
    end
    a_iv = 1'b0;
    cyc();
    n_cmp++; if (a_ov !== 1'b0) begin n_fail++; $display("FAIL stream_end_ov got %b want 0", a_ov); end
  endtask

  task automatic test_backpressure();
    a_or = 1'b0;
    a_iv = 1'b1;
    a_sel = 2'd0;
    cyc();
    n_cmp++; if (a_od !== 32'h11) begin n_fail++; $display("FAIL bp_od1 got %h want 11", a_od); end
    n_cmp++; if (a_ir !== 1'b1) begin n_fail++; $display("FAIL bp_ir1 got %b want 1", a_ir); end
    a_sel = 2'd1;
    cyc();
    n_cmp++; if (a_od !== 32'h11) begin n_fail++; $display("FAIL bp_od2 got %h want 11", a_od); end
    n_cmp++; if (a_ir !== 1'b0) begin n_fail++; $display("FAIL bp_ir2 got %b want 0", a_ir); end
    a_sel = 2'd2;
    cyc();
    n_cmp++; if (a_od !== 32'h11) begin n_fail++; $display("FAIL bp_od3 got %h want 11", a_od); end
    n_cmp++; if (a_ov !== 1'b1) begin n_fail++; $display("FAIL bp_ov3 got %b want 1", a_ov); end
    n_cmp++; if (a_ir !== 1'b0) begin n_fail++; $display("FAIL bp_ir3 got %b want 0", a_ir); end
    a_iv = 1'b0;
    a_or = 1'b1;
    cyc();
    n_cmp++; if (a_od !== 32'h22) begin n_fail++; $display("FAIL bp_drain_od got %h want 22", a_od); end
    n_cmp++; if (a_ov !== 1'b1) begin n_fail++; $display("FAIL bp_drain_ov got %b want 1", a_ov); end
    n_cmp++; if (a_ir !== 1'b1) begin n_fail++; $display("FAIL bp_drain_ir got %b want 1", a_ir); end
    cyc();
    n_cmp++; if (a_ov !== 1'b0) begin n_fail++; $display("FAIL bp_empty_ov got %b want 0", a_ov); end
  endtask

  task automatic test_range_error();
    c_data = {32'h33, 32'h22, 32'h11};
    c_or = 1'b1;
    c_iv = 1'b1;
    c_sel = 2'd2;
    cyc();
    n_cmp++; if (c_od !== 32'h33) begin n_fail++; $display("FAIL rng_ok_od got %h want 33", c_od); end
    n_cmp++; if (c_err !== 1'b0) begin n_fail++; $display("FAIL rng_ok_err got %b want 0", c_err); end
    c_sel = 2'd3;
    cyc();
    n_cmp++; if (c_od !== 32'h0) begin n_fail++; $display("FAIL rng_bad_od got %h want 0", c_od); end
    n_cmp++; if (c_ov !== 1'b1) begin n_fail++; $display("FAIL rng_bad_ov got %b want 1", c_ov); end
    n_cmp++; if (c_err !== 1'b1) begin n_fail++; $display("FAIL rng_bad_err got %b want 1", c_err); end
    c_iv = 1'b0;
    cyc();
    cyc();
    n_cmp++; if (c_err !== 1'b1) begin n_fail++; $display("FAIL rng_sticky got %b want 1", c_err); end
    c_iv = 1'b1;
    c_clr = 1'b1;
    cyc();
    n_cmp++; if (c_err !== 1'b1) begin n_fail++; $display("FAIL rng_set_wins got %b want 1", c_err); end
    c_iv = 1'b0;
    cyc();
    n_cmp++; if (c_err !== 1'b0) begin n_fail++; $display("FAIL rng_clear got %b want 0", c_err); end
    c_clr = 1'b0;
    c_iv = 1'b1;
    cyc();
    c_iv = 1'b0;
    n_cmp++; if (c_err !== 1'b1) begin n_fail++; $display("FAIL rng_reset_prep got %b want 1", c_err); end
  endtask

  task automatic test_reset_midstream();
    a_data = {32'h44, 32'h33, 32'h22, 32'h11};
    a_or = 1'b0;
    a_iv = 1'b1;
    a_sel = 2'd2;
    cyc();
    a_sel = 2'd3;
    cyc();
    a_iv = 1'b0;
    n_cmp++; if (a_ir !== 1'b0) begin n_fail++; $display("FAIL mid_full_ir got %b want 0", a_ir); end
    #3;
    rst_n = 1'b0;
    #1;
    n_cmp++; if (a_ov !== 1'b0) begin n_fail++; $display("FAIL mid_rst_ov got %b want 0", a_ov); end
    n_cmp++; if (a_od !== 32'h0) begin n_fail++; $display("FAIL mid_rst_od got %h want 0", a_od); end
    n_cmp++; if (c_err !== 1'b0) begin n_fail++; $display("FAIL mid_rst_err got %b want 0", c_err); end
    cyc();
    rst_n = 1'b1;
    a_or = 1'b1;
    cyc();
    n_cmp++; if (a_ir !== 1'b1) begin n_fail++; $display("FAIL mid_post_ir got %b want 1", a_ir); end
    n_cmp++; if (a_ov !== 1'b0) begin n_fail++; $display("FAIL mid_replay_ov got %b want 0", a_ov); end
    cyc();
    n_cmp++; if (a_ov !== 1'b0) begin n_fail++; $display("FAIL mid_replay2_ov got %b want 0", a_ov); end
  endtask

  task automatic test_degenerate();
    logic [63:0] exp [2];
    exp = '{64'hAAAA_0000_1111_2222, 64'hBBBB_3333_4444_5555};
    d_data = {64'hBBBB_3333_4444_5555, 64'hAAAA_0000_1111_2222};
    d_or = 1'b1;
    for (int i = 0; i < 4; i++) begin
      d_iv = 1'b1;
      d_sel = 1'(i);
      cyc();
      d_iv = 1'b0;
      n_cmp++; if (d_ov !== 1'b1) begin n_fail++; $display("FAIL deg_ov%0d got %b want 1", i, d_ov); end
      n_cmp++; if (d_od !== exp[i%2]) begin n_fail++; $display("FAIL deg_od%0d got %h want %h", i, d_od, exp[i%2]); end
      cyc();
      n_cmp++; if (d_ov !== 1'b0) begin n_fail++; $display("FAIL deg_gap%0d got %b want 0", i, d_ov); end
      cyc();
      n_cmp++; if (d_ov !== 1'b0) begin n_fail++; $display("FAIL deg_idle%0d got %b want 0", i, d_ov); end
    end
  endtask

  task automatic test_sweep();
    logic [7:0]  qb [$];
    logic [63:0] qd [$];
    logic [7:0]  eb;
    logic [63:0] ed;
    for (int i = 0; i < 400; i++) begin
      b_iv = 1'($urandom);
      b_sel = 3'($urandom);
      b_data = 40'({$urandom, $urandom});
      b_or = 1'($urandom);
      d_iv = 1'($urandom);
      d_sel = 1'($urandom);
      d_data = {$urandom, $urandom, $urandom, $urandom};
      d_or = 1'($urandom);
      if (i >= 390) begin
        b_iv = 1'b0; b_or = 1'b1;
        d_iv = 1'b0; d_or = 1'b1;
      end
      #1;
      if (b_ov && b_or) begin
        n_cmp++;
        if (qb.size() == 0) begin
          n_fail++; $display("FAIL sweep_b_extra got %h want none", b_od);
        end else begin
          eb = qb.pop_front();
          if (b_od !== eb) begin n_fail++; $display("FAIL sweep_b got %h want %h", b_od, eb); end
        end
      end
      if (b_iv && b_ir) qb.push_back(ref_b(b_data, b_sel));
      if (d_ov && d_or) begin
        n_cmp++;
        if (qd.size() == 0) begin
          n_fail++; $display("FAIL sweep_d_extra got %h want none", d_od);
        end else begin
          ed = qd.pop_front();
          if (d_od !== ed) begin n_fail++; $display("FAIL sweep_d got %h want %h", d_od, ed); end
        end
      end
      if (d_iv && d_ir) qd.push_back(ref_d(d_data, d_sel));
      cyc();
    end
    n_cmp++; if (qb.size() != 0 || b_ov !== 1'b0) begin n_fail++; $display("FAIL sweep_b_drain got %0d/%b want 0/0", qb.size(), b_ov); end
    n_cmp++; if (qd.size() != 0 || d_ov !== 1'b0) begin n_fail++; $display("FAIL sweep_d_drain got %0d/%b want 0/0", qd.size(), d_ov); end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_range_error();
    test_reset_midstream();
    test_degenerate();
    test_sweep();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
